fp_multiplier: RTL

Parametrised IEEE-754 binary floating-point multiplier for the coprocessor datapath, the successor to the fixed single-precision multiplier. Exponent and mantissa widths are generics, so one block serves binary32 and binary64. Operands arrive and results leave over the existing stb/ack handshake, so it drops into the same slots on the coprocessor bus. It rounds to nearest-even and handles zero, infinity, NaN and, optionally, subnormals.

---
 rtl/fp_multiplier.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/fp_multiplier.sv
// -----------------------------------------------------------------------------
// fp_multiplier
//   IEEE-754 binary floating-point multiplier with round-to-nearest-even.
//   Exponent and mantissa field widths are parameters (8/23 for binary32,
//   11/52 for binary64). Operands and result move over stb/ack handshakes.
//   Handles zero, infinity and NaN. A NaN result is always the canonical
//   quiet NaN.
//
//   Build option FP_MUL_DENORM_EN:
//     defined   - subnormal operands are normalised and subnormal results
//                 are produced with correct rounding.
//     undefined - flush-to-zero: subnormal operands count as signed zero and
//                 any result below the normal range is packed as signed zero.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   input_a/_stb/_ack        operand A (packed) and its handshake
//   input_b/_stb/_ack        operand B (packed) and its handshake
//   output_z/_stb/_ack       product (packed) and its handshake
// -----------------------------------------------------------------------------
module fp_multiplier #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [EXP_W+MAN_W:0] input_a,
  input  logic                 input_a_stb,
  output logic                 input_a_ack,
  input  logic [EXP_W+MAN_W:0] input_b,
  input  logic                 input_b_stb,
  output logic                 input_b_ack,
  output logic [EXP_W+MAN_W:0] output_z,
  output logic                 output_z_stb,
  input  logic                 output_z_ack
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int N    = MAN_W + 1;
  localparam int PW   = 2 * N;
  localparam int EW2  = EXP_W + 2;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam logic signed [EW2-1:0] E_BIAS = EW2'(BIAS);
  localparam logic signed [EW2-1:0] E_MIN  = EW2'(1 - BIAS);
  localparam logic signed [EW2-1:0] E_ONE  = EW2'(1);
  localparam logic signed [EW2-1:0] E_ZERO = EW2'(0);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [3:0] {
    GET_A, GET_B, UNPACK, SPECIAL, NORM_A, NORM_B,
    MULTIPLY, NORM_1, NORM_2, ROUND, PACK, PUT_Z
  } state_t;

  state_t r_state, w_state_nxt;

  logic [W-1:0]          r_a, r_b, r_z;
  logic                  r_a_s, r_b_s, r_z_s;
  logic signed [EW2-1:0] r_a_e, r_b_e, r_z_e;
  logic [N-1:0]          r_a_m, r_b_m, r_z_m;
  logic                  r_g, r_r, r_s;

  function automatic logic f_round_up(input logic g, input logic r, input logic s,
                                      input logic lsb);
    return g & (r | s | lsb);
  endfunction

  // The exponent field is formed modulo 2^EXP_W; it is only used when the
  // exponent is inside the normal range, where that is exact.
  function automatic logic [W-1:0] f_pack(input logic s, input logic signed [EW2-1:0] e,
                                          input logic [N-1:0] m, input logic flush);
    logic [EXP_W-1:0] field;
    field = e[EXP_W-1:0] + EXP_W'(BIAS);
    if (flush)
      return {s, {(W-1){1'b0}}};
    else if (e > E_BIAS)
      return {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (!m[MAN_W])
      return {s, {EXP_W{1'b0}}, m[MAN_W-1:0]};
    else
      return {s, field, m[MAN_W-1:0]};
  endfunction

  // Operand classification straight from the packed fields.
  logic [EXP_W-1:0] w_a_exp, w_b_exp;
  logic [MAN_W-1:0] w_a_frac, w_b_frac;
  logic w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic w_sp_nan, w_sp_inf, w_special, w_sign;
  logic [W-1:0] w_special_z;

  assign w_a_exp  = r_a[MAN_W +: EXP_W];
  assign w_b_exp  = r_b[MAN_W +: EXP_W];
  assign w_a_frac = r_a[MAN_W-1:0];
  assign w_b_frac = r_b[MAN_W-1:0];
  assign w_a_nan  = (&w_a_exp) && (w_a_frac != '0);
  assign w_b_nan  = (&w_b_exp) && (w_b_frac != '0);
  assign w_a_inf  = (&w_a_exp) && (w_a_frac == '0);
  assign w_b_inf  = (&w_b_exp) && (w_b_frac == '0);
`ifdef FP_MUL_DENORM_EN
  assign w_a_zero = (w_a_exp == '0) && (w_a_frac == '0);
  assign w_b_zero = (w_b_exp == '0) && (w_b_frac == '0);
`else
  assign w_a_zero = (w_a_exp == '0);
  assign w_b_zero = (w_b_exp == '0);
`endif
  assign w_sign      = r_a[W-1] ^ r_b[W-1];
  assign w_sp_nan    = w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_b_inf & w_a_zero);
  assign w_sp_inf    = w_a_inf | w_b_inf;
  assign w_special   = w_sp_nan | w_sp_inf | w_a_zero | w_b_zero;
  assign w_special_z = w_sp_nan ? QNAN :
                       w_sp_inf ? {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
                                  {w_sign, {(W-1){1'b0}}};

  // Full product. Both significands are normalised, so the product is in
  // [1,4); a product below 2 is pre-shifted so the mantissa leaves MULTIPLY
  // already normalised and NORM_1 normally needs no shift.
  logic [PW-1:0] w_prod, w_prod_n;
  logic [N:0]    w_m_inc;
  logic          w_flush;

  assign w_prod   = {{N{1'b0}}, r_a_m} * {{N{1'b0}}, r_b_m};
  assign w_prod_n = w_prod[PW-1] ? w_prod : {w_prod[PW-2:0], 1'b0};
  assign w_m_inc  = {1'b0, r_z_m} + {{N{1'b0}}, 1'b1};

`ifdef FP_MUL_DENORM_EN
  assign w_flush = 1'b0;
`else
  logic r_ftz;
  assign w_flush = r_ftz;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= GET_A;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    input_a_ack  = 1'b0;
    input_b_ack  = 1'b0;
    output_z_stb = 1'b0;
    case (r_state)
      GET_A: begin
        input_a_ack = 1'b1;
        if (input_a_stb) w_state_nxt = GET_B;
      end
      GET_B: begin
        input_b_ack = 1'b1;
        if (input_b_stb) w_state_nxt = UNPACK;
      end
      UNPACK:   w_state_nxt = SPECIAL;
      SPECIAL:  w_state_nxt = w_special ? PUT_Z : NORM_A;
      NORM_A:   if (r_a_m[MAN_W]) w_state_nxt = NORM_B;
      NORM_B:   if (r_b_m[MAN_W]) w_state_nxt = MULTIPLY;
      MULTIPLY: w_state_nxt = NORM_1;
      NORM_1:   if (r_z_m[MAN_W]) w_state_nxt = NORM_2;
`ifdef FP_MUL_DENORM_EN
      NORM_2:   if (!(r_z_e < E_MIN)) w_state_nxt = ROUND;
`else
      NORM_2:   w_state_nxt = ROUND;
`endif
      ROUND:    w_state_nxt = PACK;
      PACK:     w_state_nxt = PUT_Z;
      PUT_Z: begin
        output_z_stb = 1'b1;
        if (output_z_ack) w_state_nxt = GET_A;
      end
      default:  w_state_nxt = GET_A;
    endcase
  end

  always_ff @(posedge clk) begin
    case (r_state)
      GET_A: if (input_a_stb) r_a <= input_a;
      GET_B: if (input_b_stb) r_b <= input_b;
      // ---- unpack: unbias exponents, restore hidden bits
      UNPACK: begin
        r_a_s <= r_a[W-1];
        r_b_s <= r_b[W-1];
        r_a_m <= {|w_a_exp, w_a_frac};
        r_b_m <= {|w_b_exp, w_b_frac};
        r_a_e <= (w_a_exp == '0) ? E_MIN : $signed({2'b00, w_a_exp}) - E_BIAS;
        r_b_e <= (w_b_exp == '0) ? E_MIN : $signed({2'b00, w_b_exp}) - E_BIAS;
      end
      // ---- operand normalisation, one bit per cycle
      NORM_A: if (!r_a_m[MAN_W]) begin
        r_a_m <= {r_a_m[MAN_W-1:0], 1'b0};
        r_a_e <= r_a_e - E_ONE;
      end
      NORM_B: if (!r_b_m[MAN_W]) begin
        r_b_m <= {r_b_m[MAN_W-1:0], 1'b0};
        r_b_e <= r_b_e - E_ONE;
      end
      // ---- multiply and split into mantissa / guard / round / sticky
      MULTIPLY: begin
        r_z_s <= r_a_s ^ r_b_s;
        r_z_e <= r_a_e + r_b_e + (w_prod[PW-1] ? E_ONE : E_ZERO);
        r_z_m <= w_prod_n[PW-1 -: N];
        r_g   <= w_prod_n[MAN_W];
        r_r   <= w_prod_n[MAN_W-1];
        r_s   <= |w_prod_n[MAN_W-2:0];
      end
      // ---- result normalisation
      NORM_1: if (!r_z_m[MAN_W]) begin
        r_z_m <= {r_z_m[MAN_W-1:0], r_g};
        r_g   <= r_r;
        r_r   <= 1'b0;
        r_z_e <= r_z_e - E_ONE;
      end
`ifdef FP_MUL_DENORM_EN
      NORM_2: if (r_z_e < E_MIN) begin
        r_z_m <= {1'b0, r_z_m[MAN_W:1]};
        r_g   <= r_z_m[0];
        r_r   <= r_g;
        r_s   <= r_s | r_r;
        r_z_e <= r_z_e + E_ONE;
      end
`else
      NORM_2: r_ftz <= (r_z_e < E_MIN);
`endif
      // ---- round to nearest even; an all-ones mantissa carries into the exponent
      ROUND: if (f_round_up(r_g, r_r, r_s, r_z_m[0])) begin
        r_z_m <= w_m_inc[N] ? w_m_inc[N:1] : w_m_inc[N-1:0];
        if (w_m_inc[N]) r_z_e <= r_z_e + E_ONE;
      end
      default: ;
    endcase
  end

  // ---- result register
  always_ff @(posedge clk) begin
    if (rst)
      r_z <= '0;
    else if (r_state == SPECIAL && w_special)
      r_z <= w_special_z;
    else if (r_state == PACK)
      r_z <= f_pack(r_z_s, r_z_e, r_z_m, w_flush);
  end

  assign output_z = r_z;

endmodule
